// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port sequencer: IF and DM requesters, IDLE->ACCESS->RESP, ack two cycles after grant.
// Optional MEM_BOUNDS_CHECK_EN adds an out-of-range address check with a bound_err output.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 32,
    parameter int MAX_DM_RUN = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ack,
    output logic [31:0]       dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    output logic              mem_irwrite,
    input  logic [31:0]       mem_rd,
`ifdef MEM_BOUNDS_CHECK_EN
    output logic              bound_err,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_DM_RUN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant_dm;
    logic                w_grant_if;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic                w_oob;
    logic [31:0]         w_capture;

    logic [CNT_W-1:0]    r_run_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wd;
    logic                r_wflag;
    logic                r_irwrite;
    logic                r_sel_dm;
    logic                r_is_store;
    logic                r_oob;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_dm_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DM keeps priority until it has won MAX_DM_RUN grants in a row against a waiting fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_dm = dm_req && (!if_req || (r_run_cnt < CNT_W'(MAX_DM_RUN)));
                w_grant_if = if_req && !w_grant_dm;
                if (w_grant_dm || w_grant_if) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_grant_addr = w_grant_dm ? dm_addr : if_addr;

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_oob = (w_grant_addr >= ADDR_W'(DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    assign w_capture = r_oob ? 32'hDEAD_BEEF : mem_rd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_run_cnt  <= '0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_wflag    <= 1'b0;
            r_irwrite  <= 1'b0;
            r_sel_dm   <= 1'b0;
            r_is_store <= 1'b0;
            r_oob      <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!if_req) begin
                        r_run_cnt <= '0;
                    end
                    if (w_grant_dm) begin
                        r_mem_addr <= dm_addr;
                        r_mem_wd   <= dm_wdata;
                        r_wflag    <= dm_we && !w_oob;
                        r_irwrite  <= 1'b0;
                        r_sel_dm   <= 1'b1;
                        r_is_store <= dm_we;
                        r_oob      <= w_oob;
                        if (if_req && (r_run_cnt < CNT_W'(MAX_DM_RUN))) begin
                            r_run_cnt <= r_run_cnt + CNT_W'(1);
                        end
                    end else if (w_grant_if) begin
                        r_mem_addr <= if_addr;
                        r_mem_wd   <= '0;
                        r_wflag    <= 1'b0;
                        r_irwrite  <= 1'b1;
                        r_sel_dm   <= 1'b0;
                        r_is_store <= 1'b0;
                        r_oob      <= w_oob;
                        r_run_cnt  <= '0;
                    end
                end
                S_ACCESS: begin
                    if (!r_sel_dm) begin
                        r_if_rdata <= w_capture;
                    end else if (!r_is_store) begin
                        r_dm_rdata <= w_capture;
                    end
                    r_wflag   <= 1'b0;
                    r_irwrite <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Qualifying with RST lets a reset arriving mid-access kill the write in the same cycle.
    assign mem_we      = r_wflag && (r_state == S_ACCESS) && !RST;
    assign mem_irwrite = r_irwrite;
    assign mem_addr    = r_mem_addr;
    assign mem_wd      = r_mem_wd;
    assign if_ack      = (r_state == S_RESP) && !r_sel_dm;
    assign dm_ack      = (r_state == S_RESP) && r_sel_dm;
    assign if_rdata    = r_if_rdata;
    assign dm_rdata    = r_dm_rdata;
    assign busy        = (r_state != S_IDLE);

`ifdef MEM_BOUNDS_CHECK_EN
    assign bound_err = (r_state == S_RESP) && r_oob;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus grant-order, back-to-back and reset-abort sequences.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DEPTH      = 32;
    localparam int MAX_DM_RUN = 4;
    localparam int AW         = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic [31:0]       dm_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic              mem_irwrite;
    logic [31:0]       mem_rd;
    logic              busy;
`ifdef MEM_BOUNDS_CHECK_EN
    logic              bound_err;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_DM_RUN(MAX_DM_RUN)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_irwrite(mem_irwrite),
        .mem_rd(mem_rd),
`ifdef MEM_BOUNDS_CHECK_EN
        .bound_err(bound_err),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Shared memory model: combinational read, write on the rising edge.
    logic [31:0] ins_mem [DEPTH];
    logic [31:0] dat_mem [DEPTH];

    always_comb begin
        mem_rd = 32'h0;
        if (mem_addr < 32'(DEPTH)) begin
            mem_rd = mem_irwrite ? ins_mem[mem_addr[AW-1:0]] : dat_mem[mem_addr[AW-1:0]];
        end
    end

    always @(posedge CLK) begin
        if (mem_we && (mem_addr < 32'(DEPTH))) begin
            if (mem_irwrite) ins_mem[mem_addr[AW-1:0]] <= mem_wd;
            else             dat_mem[mem_addr[AW-1:0]] <= mem_wd;
        end
    end

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        bit          berr;
    } exp_t;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   ack_cnt = 0;
    int   we_cyc  = 0;
    int   ack_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every ack pops the oldest expected transaction.
    always @(negedge CLK) begin
        cyc++;
        if (mem_we) we_cyc++;
        if (if_ack || dm_ack) begin
            ack_cnt++;
            ack_cyc.push_back(cyc);
            check("ack_onehot", 32'(if_ack & dm_ack), 32'h0);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b expected none", if_ack, dm_ack);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", 32'(dm_ack), 32'(mon_e.is_dm));
                check("rdata", mon_e.is_dm ? dm_rdata : if_rdata, mon_e.rdata);
`ifdef MEM_BOUNDS_CHECK_EN
                check("bound_err", 32'(bound_err), 32'(mon_e.berr));
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic run_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input bit berr);
        int lat;
        bit got;
        exp_t e;
        wait_idle();
        e.is_dm = is_dm; e.rdata = exp_rd; e.berr = berr;
        sb.push_back(e);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(negedge CLK);
        check("acc_busy", 32'(busy), 32'h1);
        check("acc_addr", mem_addr, addr);
        check("acc_wd", mem_wd, is_dm ? wdata : 32'h0);
        check("acc_we", 32'(mem_we), 32'(is_dm & we & ~berr));
        check("acc_irwrite", 32'(mem_irwrite), 32'(!is_dm));
        lat = 1;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge CLK);
            lat++;
            if (is_dm ? dm_ack : if_ack) got = 1'b1;
        end
        check("ack_latency", 32'(lat), 32'h2);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        int   n;
        int   idle_cnt;
        int   base;
        int   we_base;
        exp_t e;

        for (int i = 0; i < DEPTH; i++) begin
            ins_mem[i] = 32'hC0DE_0000 | 32'(i);
            dat_mem[i] = 32'(i * 5 + 2);
        end
        vecs[0] = '{1'b0, 1'b0, 32'd3,  32'h0,         32'hC0DE_0003};
        vecs[1] = '{1'b1, 1'b1, 32'd2,  32'h7,         32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'd2,  32'h0,         32'h7};
        vecs[3] = '{1'b1, 1'b0, 32'd0,  32'h0,         32'h2};
        vecs[4] = '{1'b1, 1'b0, 32'd1,  32'h0,         32'h7};
        vecs[5] = '{1'b0, 1'b0, 32'd31, 32'h0,         32'hC0DE_001F};
        vecs[6] = '{1'b1, 1'b1, 32'd31, 32'h3C3C_A5A5, 32'h7};
        vecs[7] = '{1'b1, 1'b0, 32'd31, 32'h0,         32'h3C3C_A5A5};
        vecs[8] = '{1'b0, 1'b0, 32'd0,  32'h0,         32'hC0DE_0000};
        vecs[9] = '{1'b1, 1'b0, 32'd2,  32'h0,         32'h7};

        RST = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_acks", 32'({if_ack, dm_ack}), 32'h0);
        check("rst_mem_ctl", 32'({mem_we, mem_irwrite}), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);
        end

        // Both requesters held: DM x4, then forced IF, then DM again.
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            e.is_dm = (i != 4); e.rdata = (i == 4) ? 32'hC0DE_0007 : 32'd22; e.berr = 1'b0;
            sb.push_back(e);
        end
        ack_cyc.delete();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd4; if_req = 1'b1; if_addr = 32'd7;
        seen = 0; n = 0;
        while (seen < 6 && n < 40) begin
            @(negedge CLK);
            n++;
            if (if_ack || dm_ack) seen++;
        end
        dm_req = 1'b0; if_req = 1'b0;
        @(negedge CLK);
        check("arb_ack_count", 32'(ack_cyc.size()), 32'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < ack_cyc.size()) check("arb_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // Back-to-back loads: single idle cycle between acks.
        wait_idle();
        e.is_dm = 1'b1; e.berr = 1'b0;
        e.rdata = 32'h2; sb.push_back(e);
        e.rdata = 32'h7; sb.push_back(e);
        ack_cyc.delete();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd0;
        seen = 0; n = 0; idle_cnt = 0; base = 0;
        while (seen < 2 && n < 20) begin
            @(negedge CLK);
            n++;
            if (dm_ack) begin
                seen++;
                if (seen == 1) begin
                    base = n;
                    dm_addr = 32'd1;
                end else begin
                    dm_req = 1'b0;
                end
            end else if (!busy && seen == 1) begin
                idle_cnt++;
            end
        end
        check("b2b_first_latency", 32'(base), 32'd2);
        check("b2b_ack_count", 32'(seen), 32'd2);
        check("b2b_idle_cycles", 32'(idle_cnt), 32'd1);
        @(negedge CLK);
        if (ack_cyc.size() == 2) check("b2b_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        else check("b2b_ack_recorded", 32'(ack_cyc.size()), 32'd2);

        // Reset during the ACCESS cycle of a store.
        wait_idle();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd5; dm_wdata = 32'h55;
        @(negedge CLK);
        check("rst_store_we_before", 32'(mem_we), 32'h1);
        RST = 1'b1;
        #1;
        check("rst_store_we_abort", 32'(mem_we), 32'h0);
        base = ack_cnt;
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge CLK);
        check("rst_store_idle", 32'(busy), 32'h0);
        check("rst_store_rdata", dm_rdata, 32'h0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_store_no_ack", 32'(ack_cnt), 32'(base));
        check("rst_store_mem", dat_mem[5], 32'd27);

`ifdef MEM_BOUNDS_CHECK_EN
        we_base = we_cyc;
        run_txn(1'b1, 1'b1, 32'd40, 32'h1234_5678, 32'h0, 1'b1);
        @(negedge CLK);
        #1;
        check("oob_no_write", 32'(we_cyc), 32'(we_base));
        run_txn(1'b1, 1'b0, 32'd40, 32'h0, 32'hDEAD_BEEF, 1'b1);
`else
        we_base = we_cyc;
        run_txn(1'b1, 1'b0, 32'd5, 32'h0, 32'd27, 1'b0);
        @(negedge CLK);
        #1;
        check("load_no_write", 32'(we_cyc), 32'(we_base));
`endif

        repeat (2) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and arbitrates the single shared instruction/data memory port of the multicycle CPU between two requesters:
  - the fetch unit (IF);
  - the load/store unit (DM).
- Drives the memory's word address, write data, write enable and IRWrite select, and registers its combinational read data.
- Returns a one-cycle ack pulse to the granted requester.
- Sits between the control unit/datapath and the shared memory. Only this block drives the memory.

Parameters:
- ADDR_W, 32: width of the address buses; addresses are word indices.
- DEPTH, 32: number of words in each memory array; used by the bounds check.
- MAX_DM_RUN, 4: consecutive DM grants allowed while if_req is pending before IF is forced through.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  32  fetched instruction, registered.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load; sampled with dm_req.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle pulse; dm_rdata is valid in the same cycle for loads.
- dm_rdata  out  32  load data, registered.
- mem_addr  out  ADDR_W  memory address.
- mem_wd  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_irwrite  out  1  1 selects the instruction array, 0 selects the data array.
- mem_rd  in  32  memory read data (combinational).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - all outputs 0, state IDLE, run counter 0;
  - if_rdata and dm_rdata are cleared to 0.
- States: IDLE, ACCESS, RESP.
- IDLE, grant decision:
  - dm_req=1 and (if_req=0 or run_cnt<MAX_DM_RUN) → grant DM.
  - else if_req=1 → grant IF.
  - else stay in IDLE.
- IDLE, on a grant:
  - register mem_addr, mem_wd (dm_wdata for DM, 0 for IF), the write flag (DM grant and dm_we=1) and mem_irwrite (1 only for IF);
  - go to ACCESS.
- ACCESS:
  - mem_we = write flag & ~RST, so a write is aborted by reset.
  - For reads, capture mem_rd at the closing edge into if_rdata or dm_rdata. For a store, dm_rdata is unchanged.
  - Go to RESP.
- RESP:
  - assert if_ack or dm_ack for exactly 1 cycle;
  - mem_we=0 and mem_irwrite=0;
  - go to IDLE.
- Latency: a request sampled in IDLE at cycle T gets its ack in cycle T+2. Throughput is one transaction per 3 cycles.
- Requester rule: the requester deasserts req, or presents a new request, in the cycle after ack. A req still high in the following IDLE cycle is a new request.
- Run counter:
  - +1 on a DM grant while if_req=1, saturating at MAX_DM_RUN;
  - cleared on an IF grant or whenever if_req=0 in IDLE.
- Simultaneous requests: DM wins until run_cnt reaches MAX_DM_RUN, then IF wins once.
- Request changes while not in IDLE: ignored; inputs are sampled only in IDLE.
- Output stability: mem_addr and mem_wd hold their last values in IDLE and RESP.
- Reset mid-operation: return to IDLE next cycle with no ack and no pending write; captured rdata is cleared.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - A granted address ≥ DEPTH forces the write flag to 0 and the captured rdata to 32'hDEADBEEF.
  - Adds output bound_err (1 bit). It pulses with the ack of that transaction and resets to 0.
- Undefined:
  - No bound_err port.
  - Addresses pass through unchecked.

Test Plan:
- RST high for 2 cycles → all outputs 0, busy=0. Then if_req=1, if_addr=3 with InsMem[3]=X → mem_irwrite=1 in ACCESS, if_ack plus if_rdata=X at T+2.
- dm_req=1, dm_we=1, dm_addr=2, dm_wdata=32'h7 → mem_we=1 for exactly 1 cycle. A follow-up load of address 2 returns dm_rdata=32'h7 and mem_irwrite=0.
- if_req and dm_req both held high with MAX_DM_RUN=4 → grant order DM, DM, DM, DM, IF, DM, and each ack is 3 cycles apart.
- Store to addr 5 with RST asserted during ACCESS → mem_we=0, no dm_ack, DaMem[5] unchanged, state IDLE next cycle.
- Back-to-back loads of addr 0 then addr 1 (values 2, 7) → dm_ack in cycles T+2 and T+5 with dm_rdata 2 then 7. busy low only for the single IDLE cycle in between.
- Built with MEM_BOUNDS_CHECK_EN, store to addr 40 → mem_we=0 throughout, bound_err=1 with dm_ack.
